// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx: WS2812 strip frame serialiser.
// On start it fetches one 24-bit colour per LED and sends each one MSB-first as
// NRZ high/low pulses. It then holds dout low for the latch gap and pulses
// frame_done. All outputs are registered from next-state values computed in a
// single combinational block.
module ws2812_frame_tx #(
    parameter int unsigned NUM_LEDS     = 60,
    parameter int unsigned T0H          = 20,
    parameter int unsigned T1H          = 40,
    parameter int unsigned TBIT         = 63,
    parameter int unsigned RESET_CYCLES = 15000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        pix_req,
    output logic [5:0]  pix_addr,
    input  logic [23:0] pix_data,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned MAX_CNT = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]        state,      state_nxt;
    logic [CNT_W-1:0]  cnt,        cnt_nxt;
    logic [BIT_W-1:0]  bit_idx,    bit_idx_nxt;
    logic [PIX_W-1:0]  shreg,      shreg_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              req_nxt;
    logic              dout_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    logic              bit_end;
    logic [CNT_W-1:0]  high_cur;
    logic [CNT_W-1:0]  high_next_bit;

    // High-time thresholds for the bit now on the wire and for the one after the shift.
    always_comb begin
        high_cur      = shreg[PIX_W-1] ? CNT_W'(T1H) : CNT_W'(T0H);
        high_next_bit = shreg[PIX_W-2] ? CNT_W'(T1H) : CNT_W'(T0H);
        bit_end       = (cnt == CNT_W'(TBIT - 1));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            pix_req    <= 1'b0;
            pix_addr   <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            pix_req    <= req_nxt;
            pix_addr   <= addr_nxt;
            dout       <= dout_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state and next-output decode; dout for the coming cycle is derived from the
    // counter and bit values that cycle will hold.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        addr_nxt    = pix_addr;
        req_nxt     = 1'b0;
        dout_nxt    = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                addr_nxt = '0;
                if (start) begin
                    state_nxt = S_FETCH;
                    req_nxt   = 1'b1;
                    addr_nxt  = ADDR_W'(1);
                    busy_nxt  = 1'b1;
                end
            end

            S_FETCH: begin
                shreg_nxt   = pix_data;
                bit_idx_nxt = BIT_W'(PIX_W - 1);
                cnt_nxt     = '0;
                state_nxt   = S_SEND;
                dout_nxt    = (CNT_W'(0) < (pix_data[PIX_W-1] ? CNT_W'(T1H) : CNT_W'(T0H)));
            end

            S_SEND: begin
                if (!bit_end) begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    dout_nxt = ((cnt + CNT_W'(1)) < high_cur);
                end else if (bit_idx != '0) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {shreg[PIX_W-2:0], 1'b0};
                    bit_idx_nxt = bit_idx - BIT_W'(1);
                    dout_nxt    = (CNT_W'(0) < high_next_bit);
                end else if (pix_addr < ADDR_W'(NUM_LEDS)) begin
                    // Fetch cycle adds one extra low cycle to this LED's last bit.
                    cnt_nxt   = '0;
                    addr_nxt  = pix_addr + ADDR_W'(1);
                    req_nxt   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                    state_nxt = S_LATCH;
                end
            end

            S_LATCH: begin
                addr_nxt = '0;
                if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                addr_nxt  = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ws2812_frame_tx.md
# ws2812_frame_tx

Serial frame transmitter for a daisy-chained WS2812-class LED strip. It sits directly downstream of the per-LED colour generator. On each frame request it fetches one 24-bit colour per LED through an address/data port and serialises it MSB-first onto a single NRZ data line. It then holds the line low for the latch (reset) gap and reports frame completion so the upstream controller can advance its animation state.

## Interface
- NUM_LEDS, 60: LEDs per frame; addresses run 1..NUM_LEDS.
- T0H, 20: high time of a '0' bit, clk cycles (0.4 us @ 50 MHz).
- T1H, 40: high time of a '1' bit, clk cycles.
- TBIT, 63: total bit period, clk cycles; requires 0 < T0H < T1H < TBIT.
- RESET_CYCLES, 15000: latch gap, dout low, clk cycles (300 us @ 50 MHz).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- pix_req  output  1  high for exactly one cycle per LED (FETCH state).
- pix_addr  output  6  LED index 1..NUM_LEDS; 0 when idle or in latch gap.
- pix_data  input  24  colour for pix_addr, wire order, bit 23 sent first; must be valid in the pix_req cycle.
- dout  output  1  serial data to strip.
- busy  output  1  high from the first FETCH through the last latch cycle.
- frame_done  output  1  one-cycle pulse after the latch gap completes.

## Operation
- Reset values: dout=0, pix_req=0, pix_addr=0, busy=0, frame_done=0, state=IDLE. Internal bit counter, timing counter and shift register are cleared.
- States: IDLE, FETCH, SEND, LATCH.
- IDLE: dout=0. If start=1, go to FETCH with pix_addr=1. start in any other state is ignored and is not queued.
- FETCH (1 cycle): pix_req=1, busy=1. pix_data is latched into the 24-bit shift register at the end of the cycle. Bit index is set to 23 and the timing counter to 0. Go to SEND.
- SEND: timing counter runs 0..TBIT-1. dout=1 while counter < (current bit ? T1H : T0H), otherwise 0. At counter=TBIT-1:
  - if bit index > 0: shift left and decrement bit index;
  - if bit index = 0 and pix_addr < NUM_LEDS: increment pix_addr and go to FETCH;
  - if bit index = 0 and pix_addr = NUM_LEDS: go to LATCH.
- FETCH between LEDs adds one extra low cycle to the last bit of the previous LED. This is allowed by protocol tolerance.
- LATCH: dout=0, pix_addr=0. Counter runs 0..RESET_CYCLES-1, then go to IDLE.
- frame_done=1 in the first IDLE cycle after LATCH. busy=0 in that same cycle. A start sampled in that cycle is accepted, giving back-to-back frames.
- Counters: timing counter width covers max(TBIT, RESET_CYCLES)-1 (≥14 bits for the defaults). Bit index is 5 bits. There is no wrap-around: every counter is reloaded on each state change.
- pix_data changes outside the FETCH cycle have no effect on dout.
- Reset asserted mid-frame: the next cycle shows all reset values, the frame is abandoned with no frame_done, and dout drops low immediately.

## Timing
- start high in IDLE at edge k → FETCH in cycle k+1 (pix_req=1, pix_addr=1, busy=1).
- First dout rising edge in cycle k+2. All outputs are registered.
- Cycles per LED: 1 + 24·TBIT.
- Busy duration: NUM_LEDS·(1+24·TBIT) + RESET_CYCLES cycles, followed by a single frame_done cycle.
- pix_req spacing: 1+24·TBIT cycles; exactly NUM_LEDS pulses per frame.

## Test plan
- Bench parameters: NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, RESET_CYCLES=10.
- Reset with start=1: all outputs 0 for the reset cycle; the first FETCH happens one cycle after reset deasserts.
- Single frame, pix_data=24'hA50000 for addr 1 and 24'h00000F for addr 2:
  - dout high-runs decode to bits 101001010…0 then 0…01111;
  - each '1' bit is high 4 cycles and each '0' bit is high 2 cycles;
  - busy stays high exactly 300 cycles;
  - exactly 2 pix_req pulses, addr 1 then 2;
  - frame_done rises at cycle 301.
- Back-to-back: start held high continuously → the next FETCH follows the frame_done cycle with no idle gap, and pix_addr restarts at 1.
- start pulsed during SEND and during LATCH → ignored: frame length is unchanged and no second frame starts.
- Reset asserted during LED 2, bit 10 → dout=0, busy=0, pix_addr=0 the next cycle, and no frame_done. A new start then produces a full 300-cycle frame.
- pix_data toggled randomly outside pix_req cycles → dout waveform identical to the stable-data run.
